// File: rtl/pipe_mon_pkg.sv
// Shared constants and helpers for the pipeline commit monitor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_mon_pkg;

   localparam int DEF_NUM_PIPES  = 2;
   localparam int DEF_NUM_STAGES = 4;
   localparam int DEF_CNT_W      = 8;
   localparam int DEF_CNT_SAT    = 132;
   localparam int DEF_MAX_CYCLES = 50;

   // Flat bit position of stage 'stage' (1-based) of pipe 'pipe' in stall/stage_vld.
   function automatic int stage_idx(input int pipe, input int stage, input int num_stages);
      return pipe * num_stages + stage - 1;
   endfunction

endpackage

// File: rtl/pipe_stage_tracker.sv
// Tracks a single token through one pipeline's stage chain and reports its commit.
// Latency: stage 1 is combinational on start; commit is NUM_STAGES cycles after start with no stalls.
// Backpressure: a stalled stage holds its token; flush clears the chain and any pending commit.
module pipe_stage_tracker
   import pipe_mon_pkg::*;
#(
   parameter int NUM_STAGES = DEF_NUM_STAGES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  valid_s1,
   input  logic [NUM_STAGES-1:0] stall,
   input  logic                  flush,
   output logic [NUM_STAGES-1:0] stage_vld,
   output logic                  commit,
   output logic                  killed
);

   logic                  s1_vld;
   logic [NUM_STAGES-1:1] stg_q;

   // Only the launch cycle can place a token in stage 1, so later valid_s1 is ignored.
   assign s1_vld    = start & valid_s1 & ~stall[0];
   assign stage_vld = {stg_q, s1_vld};

   // Stage k advances from k-1 unless stage k itself is stalled; flush wins over both.
   always_ff @(posedge clk) begin
      if (rst) begin
         stg_q <= '0;
      end else begin
         for (int k = 1; k < NUM_STAGES; k++) begin
            if (flush) begin
               stg_q[k] <= 1'b0;
            end else if (!stall[k]) begin
               stg_q[k] <= stage_vld[k-1] & ~stall[k-1];
            end
         end
      end
   end

   // Commit pulses the cycle after the last stage drains; flush suppresses it.
   always_ff @(posedge clk) begin
      if (rst) begin
         commit <= 1'b0;
      end else begin
         commit <= stage_vld[NUM_STAGES-1] & ~stall[NUM_STAGES-1] & ~flush;
      end
   end

   // Sticky record that a flush hit a live token.
   always_ff @(posedge clk) begin
      if (rst) begin
         killed <= 1'b0;
      end else if (flush && (|stage_vld)) begin
         killed <= 1'b1;
      end
   end

endmodule

// File: rtl/pipe_commit_monitor.sv
// Launches one tracked token per pipe, times it, and flags first/second end and timeout.
// Latency: start 1 cycle after issue_en; commit NUM_STAGES cycles after start plus stall cycles.
// Backpressure: per-stage stall holds tokens; flush kills a pipe's token; no upstream ready.
module pipe_commit_monitor
   import pipe_mon_pkg::*;
#(
   parameter int NUM_PIPES  = DEF_NUM_PIPES,
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int CNT_SAT    = DEF_CNT_SAT,
   parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            issue_en,
   input  logic [NUM_PIPES-1:0]            valid_s1,
   input  logic [NUM_PIPES*NUM_STAGES-1:0] stall,
   input  logic [NUM_PIPES-1:0]            flush,
   input  logic [NUM_PIPES-1:0]            end_sel,
   output logic                            start,
   output logic                            started,
   output logic                            ended,
   output logic                            second_end,
   output logic                            timeout,
   output logic [CNT_W-1:0]                cycle_cnt,
   output logic [NUM_PIPES-1:0]            commit,
   output logic [NUM_PIPES-1:0]            killed,
   output logic [NUM_PIPES*NUM_STAGES-1:0] stage_vld,
   output logic                            iend
);

   localparam logic [CNT_W-1:0] SAT_V = CNT_W'(CNT_SAT);
   localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CYCLES);

   logic             edcond;
   logic [CNT_W-1:0] cnt_nxt;

   // One stage chain per pipe, sliced out of the flat stall/stage_vld buses.
   for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
      pipe_stage_tracker #(
         .NUM_STAGES (NUM_STAGES)
      ) u_trk (
         .clk       (clk),
         .rst       (rst),
         .start     (start),
         .valid_s1  (valid_s1[p]),
         .stall     (stall[stage_idx(p, 1, NUM_STAGES) +: NUM_STAGES]),
         .flush     (flush[p]),
         .stage_vld (stage_vld[stage_idx(p, 1, NUM_STAGES) +: NUM_STAGES]),
         .commit    (commit[p]),
         .killed    (killed[p])
      );
   end

   // End condition and the single first-end pulse, however many pipes commit together.
   always_comb begin
      edcond = (|(commit & end_sel)) & started;
      iend   = edcond & ~ended & (cycle_cnt <= MAX_V);
   end

   // Next counter value, saturating; used so timeout lines up with the count that crosses the limit.
   always_comb begin
      cnt_nxt = cycle_cnt;
      if ((start || started) && (cycle_cnt < SAT_V)) begin
         cnt_nxt = cycle_cnt + CNT_W'(1);
      end
   end

   // Launch pulse (one cycle only, never re-armed until reset) and sticky started.
   always_ff @(posedge clk) begin
      if (rst) begin
         start   <= 1'b0;
         started <= 1'b0;
      end else begin
         start   <= issue_en & ~start & ~started;
         started <= started | start;
      end
   end

   // Cycle counter since launch.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cnt_nxt;
      end
   end

   // Sticky progress flags; timeout is raised as the count steps past MAX_CYCLES without an end.
   always_ff @(posedge clk) begin
      if (rst) begin
         ended      <= 1'b0;
         second_end <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         ended      <= ended | iend;
         second_end <= second_end | (edcond & ended);
         timeout    <= timeout | (started & ~ended & ~iend & (cnt_nxt > MAX_V));
      end
   end

endmodule

// File: tb/tb_pipe_commit_monitor.sv
// Scoreboard bench for pipe_commit_monitor: expected commits queued at launch, checked on commit.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_commit_monitor;

   localparam int NP = 2;
   localparam int NS = 4;
   localparam int CW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              issue_en;
   logic [NP-1:0]     valid_s1;
   logic [NP*NS-1:0]  stall;
   logic [NP-1:0]     flush;
   logic [NP-1:0]     end_sel;
   logic              start, started, ended, second_end, timeout, iend;
   logic [CW-1:0]     cycle_cnt;
   logic [NP-1:0]     commit, killed;
   logic [NP*NS-1:0]  stage_vld;

   typedef struct {
      int pipe;
      int cnt;
      bit iend;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   iend_seen = 0;

   pipe_commit_monitor #(
      .NUM_PIPES  (NP),
      .NUM_STAGES (NS),
      .CNT_W      (CW),
      .CNT_SAT    (132),
      .MAX_CYCLES (50)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .issue_en   (issue_en),
      .valid_s1   (valid_s1),
      .stall      (stall),
      .flush      (flush),
      .end_sel    (end_sel),
      .start      (start),
      .started    (started),
      .ended      (ended),
      .second_end (second_end),
      .timeout    (timeout),
      .cycle_cnt  (cycle_cnt),
      .commit     (commit),
      .killed     (killed),
      .stage_vld  (stage_vld),
      .iend       (iend)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      issue_en = 1'b0;
      valid_s1 = '0;
      stall    = '0;
      flush    = '0;
      end_sel  = '0;
      tick();
      chk("rst_clear", {start, started, ended, second_end, timeout, iend,
                        commit, killed, stage_vld, cycle_cnt}, 32'd0);
      rst       = 1'b0;
      iend_seen = 0;
      exp_q.delete();
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain", exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Commit monitor: every observed commit must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (iend) iend_seen++;
      for (int p = 0; p < NP; p++) begin
         if (commit[p]) begin
            if (exp_q.size() == 0) begin
               chk("commit_unexpected", p, 32'hFF);
            end else begin
               e = exp_q.pop_front();
               chk("commit_pipe", p, e.pipe);
               chk("commit_cnt", cycle_cnt, e.cnt);
               chk("commit_iend", iend, e.iend);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      tick();
      do_reset();

      // Plain run, issue_en and valid_s1 held high: single launch, commit at count 4.
      valid_s1 = 2'b01; end_sel = 2'b01; issue_en = 1'b1;
      exp_q.push_back('{pipe: 0, cnt: NS, iend: 1'b1});
      tick();
      chk("t1_start", start, 1);
      chk("t1_cnt0", cycle_cnt, 0);
      chk("t1_s1", stage_vld, 8'h01);
      tick();
      chk("t1_start_clr", start, 0);
      chk("t1_started", started, 1);
      chk("t1_s2", stage_vld, 8'h02);
      wait_drain(20);
      chk("t1_ended", ended, 1);
      chk("t1_iend_cnt", iend_seen, 1);
      chk("t1_second", second_end, 0);
      chk("t1_timeout", timeout, 0);

      // Stage 3 of pipe 0 stalled for 5 cycles: commit moves from 4 to 9.
      do_reset();
      valid_s1 = 2'b01; end_sel = 2'b01; issue_en = 1'b1;
      exp_q.push_back('{pipe: 0, cnt: NS + 5, iend: 1'b1});
      tick(); issue_en = 1'b0;
      tick();
      tick();
      stall = 8'h04;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t2_hold_s3", stage_vld, 8'h04);
         tick();
      end
      stall = '0;
      wait_drain(20);
      chk("t2_ended", ended, 1);

      // Flush pipe 1 while its token is in stage 2: no commit, killed, no end.
      do_reset();
      valid_s1 = 2'b10; end_sel = 2'b10; issue_en = 1'b1;
      tick(); issue_en = 1'b0;
      tick();
      chk("t3_s2", stage_vld, 8'h20);
      flush = 2'b10;
      tick();
      flush = 2'b00;
      chk("t3_cleared", stage_vld, 8'h00);
      chk("t3_killed", killed, 2'b10);
      repeat (8) tick();
      chk("t3_ended", ended, 0);
      chk("t3_killed_sticky", killed, 2'b10);

      // Stage 2 stalled 60 cycles: timeout at count 51, late commit gives no iend, count saturates.
      do_reset();
      valid_s1 = 2'b01; end_sel = 2'b01; issue_en = 1'b1;
      tick(); issue_en = 1'b0;
      tick();
      stall = 8'h02;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         chk("t4_cnt", cycle_cnt, i);
         chk("t4_timeout", timeout, (i >= 51) ? 1 : 0);
         if (i < 60) tick();
      end
      tick();
      stall = '0;
      exp_q.push_back('{pipe: 0, cnt: NS + 60, iend: 1'b0});
      wait_drain(20);
      repeat (80) tick();
      chk("t4_sat", cycle_cnt, 132);
      chk("t4_ended", ended, 0);
      chk("t4_timeout_sticky", timeout, 1);
      chk("t4_iend_cnt", iend_seen, 0);

      // Both pipes commit together: one iend, no second end.
      do_reset();
      valid_s1 = 2'b11; end_sel = 2'b11; issue_en = 1'b1;
      exp_q.push_back('{pipe: 0, cnt: NS, iend: 1'b1});
      exp_q.push_back('{pipe: 1, cnt: NS, iend: 1'b1});
      tick(); issue_en = 1'b0;
      wait_drain(20);
      chk("t5_iend_cnt", iend_seen, 1);
      chk("t5_ended", ended, 1);
      chk("t5_second", second_end, 0);

      // Relaunch after reset; pipe 1 delayed 3 cycles gives a second end after the first.
      do_reset();
      valid_s1 = 2'b11; end_sel = 2'b11; issue_en = 1'b1;
      exp_q.push_back('{pipe: 0, cnt: NS, iend: 1'b1});
      exp_q.push_back('{pipe: 1, cnt: NS + 3, iend: 1'b0});
      tick(); issue_en = 1'b0;
      tick(); stall = 8'h20;
      tick();
      tick();
      tick(); stall = '0;
      tick();
      chk("t6_second_pre", second_end, 0);
      chk("t6_ended", ended, 1);
      wait_drain(20);
      chk("t6_second", second_end, 1);
      chk("t6_iend_cnt", iend_seen, 1);

      // Reset with a token in stage 3: everything clears, no commit follows.
      do_reset();
      valid_s1 = 2'b01; end_sel = 2'b01; issue_en = 1'b1;
      tick(); issue_en = 1'b0;
      tick();
      tick();
      chk("t7_s3", stage_vld, 8'h04);
      rst = 1'b1;
      tick();
      chk("t7_rst_clear", {start, started, ended, second_end, timeout, iend,
                           commit, killed, stage_vld, cycle_cnt}, 32'd0);
      rst = 1'b0;
      repeat (8) tick();
      chk("t7_idle", {started, ended, commit, stage_vld}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_commit_monitor.md
PIPE_COMMIT_MONITOR -- requirements
Module: pipe_commit_monitor

Interface
REQ-001 SHALL have parameter NUM_PIPES, 2: independent pipelines tracked (legal 1..4).
REQ-002 SHALL have parameter NUM_STAGES, 4: stages per pipeline (legal 2..8).
REQ-003 SHALL have parameter CNT_W, 8: cycle-counter width.
REQ-004 SHALL have parameter CNT_SAT, 132: counter saturation value (< 2^CNT_W).
REQ-005 SHALL have parameter MAX_CYCLES, 50: last cycle-count value at which an end is accepted.
REQ-006 SHALL use clk, input, 1: clock; all state on rising edge.
REQ-007 SHALL use rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have issue_en, input, 1: request to launch the tracked transaction.
REQ-009 SHALL have valid_s1, input, NUM_PIPES: per-pipe stage-1 valid from the DUT.
REQ-010 SHALL have stall, input, NUM_PIPES*NUM_STAGES: bit p*NUM_STAGES+k-1 = stall of stage k, pipe p.
REQ-011 SHALL have flush, input, NUM_PIPES: per-pipe kill of any tracked token.
REQ-012 SHALL have end_sel, input, NUM_PIPES: pipes whose commit counts as end condition.
REQ-013 SHALL have start, started, ended, second_end, timeout, output, 1 each: progress flags.
REQ-014 SHALL have cycle_cnt, output, CNT_W: cycles since start.
REQ-015 SHALL have commit, killed, output, NUM_PIPES: per-pipe commit pulse and sticky kill.
REQ-016 SHALL have stage_vld, output, NUM_PIPES*NUM_STAGES: token occupancy per stage (same bit layout as stall).
REQ-017 SHALL have iend, output, 1: combinational first-end pulse.

Function
REQ-018 start SHALL go 1 the cycle after issue_en=1 while start=0 and started=0, and SHALL be cleared the cycle after it is 1; started SHALL set the cycle after start and stay set.
REQ-019 cycle_cnt SHALL increment each cycle (start|started) holds, saturating at CNT_SAT.
REQ-020 Stage 1 of pipe p SHALL be combinational: stage_vld = start & valid_s1[p] & ~stall_s1[p].
REQ-021 Stage k>=2 register SHALL load (stage k-1 & ~stall k-1) only when stall k=0, else hold.
REQ-022 commit[p] SHALL be registered: (stage N & ~stall N) from previous cycle, one-cycle pulse.
REQ-023 flush[p] SHALL clear all stage registers and next-cycle commit of pipe p, taking priority over stall/load; killed[p] SHALL set if any stage of p was occupied.
REQ-024 Zero-stall latency start-to-commit SHALL be NUM_STAGES cycles; each stall cycle on the token's stage adds one.
REQ-025 edcond SHALL be |(commit & end_sel) & started.
REQ-026 iend SHALL equal edcond & ~ended & (cycle_cnt <= MAX_CYCLES); ended SHALL set on iend and stay set.
REQ-027 second_end SHALL set (sticky) on the first edcond with ended=1 seen in an earlier cycle.
REQ-028 timeout SHALL set (sticky) when started & ~ended & cycle_cnt > MAX_CYCLES.
REQ-029 Simultaneous commits on several selected pipes SHALL produce a single iend.
REQ-030 Only one token per pipe SHALL be tracked; later valid_s1 after start is ignored.

Reset
REQ-031 rst SHALL clear all outputs, stage registers, cycle_cnt, killed to 0 in the following cycle, including mid-flight; reset has priority over flush, stall and issue_en.
REQ-032 After reset, issue_en=1 SHALL relaunch tracking normally.

Structure
REQ-033 Stage-index helper function and default parameter constants SHALL live in package pipe_mon_pkg.
REQ-034 Per-pipe stage chain SHALL be sub-module pipe_stage_tracker, instanced NUM_PIPES times via generate.

Verification
REQ-035 No stalls, NUM_STAGES=4, valid_s1[0]=1 at start, end_sel=01 -> commit[0] at cycle_cnt 4, iend same cycle, ended next.
REQ-036 Stall stage 3 of pipe 0 for 5 cycles -> commit[0] delayed exactly 5 cycles, stage_vld holds stage 3.
REQ-037 flush[1] while token in stage 2 -> no commit[1], killed[1]=1, ended stays 0 if end_sel=10.
REQ-038 Stall held 60 cycles -> timeout=1 when cycle_cnt=51, later commit gives no iend; cycle_cnt stops at 132.
REQ-039 Both pipes commit same cycle, end_sel=11 -> one iend pulse; a later re-issue via rst sets second_end only after ended.
REQ-040 rst asserted with token in stage 3 -> all outputs 0 next cycle, no commit emitted.
